// File: rtl/count_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// count_reporter: snapshots two 64-bit counts on Sample and streams {header, delta0, delta1} as 16-bit beats.
// Optional macro REPORTER_CHECKSUM_EN appends an XOR checksum beat.  Rev 1.0
module count_reporter #(
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [63:0] Count0,
  input  logic [63:0] Count1,
  input  logic        Sample,
  output logic [15:0] Dout,
  output logic        Dvalid,
  input  logic        Dready,
  output logic        Dlast,
  output logic        Busy,
  output logic        Overrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_C0   = 3'd2,
    S_C1   = 3'd3,
    S_CK   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  seq_q, seq_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [63:0] prev0_q, prev1_q;
  logic [63:0] delta0_q, delta1_q;

  logic        hs;
  logic        last_beat;
  logic        last_hs;
  logic        capture;

`ifdef REPORTER_CHECKSUM_EN
  function automatic logic [15:0] fold16(input logic [63:0] v);
    return v[63:48] ^ v[47:32] ^ v[31:16] ^ v[15:0];
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    last_beat = 1'b0;
    Dout      = 16'h0000;
    Busy      = (state_q != S_IDLE);
    Dvalid    = Busy;

    // Beat index 0 selects the most significant halfword.
    case (state_q)
      S_HEAD: Dout = {HDR_TAG, seq_q};
      S_C0:   Dout = 16'(delta0_q >> {~idx_q, 4'b0000});
      S_C1: begin
        Dout = 16'(delta1_q >> {~idx_q, 4'b0000});
`ifndef REPORTER_CHECKSUM_EN
        last_beat = (idx_q == 2'd3);
`endif
      end
`ifdef REPORTER_CHECKSUM_EN
      S_CK: begin
        Dout      = {HDR_TAG, seq_q} ^ fold16(delta0_q) ^ fold16(delta1_q);
        last_beat = 1'b1;
      end
`endif
      default: ;
    endcase

    Dlast   = last_beat;
    hs      = Dvalid && Dready;
    last_hs = hs && last_beat;

    if (Busy && !last_hs && Sample) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    // A request landing on the last-beat edge re-arms pending while the queued one starts.
    if (last_hs) begin
      seq_d     = seq_q + 8'd1;
      capture   = pending_q || Sample;
      pending_d = pending_q && Sample;
    end
    if (state_q == S_IDLE && Sample) capture = 1'b1;

    case (state_q)
      S_IDLE: if (Sample) state_d = S_HEAD;
      S_HEAD: if (hs) begin
        state_d = S_C0;
        idx_d   = 2'd0;
      end
      S_C0: if (hs) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_C1;
      end
      S_C1: if (hs) begin
        idx_d = idx_q + 2'd1;
`ifdef REPORTER_CHECKSUM_EN
        if (idx_q == 2'd3) state_d = S_CK;
`else
        if (idx_q == 2'd3) state_d = capture ? S_HEAD : S_IDLE;
`endif
      end
`ifdef REPORTER_CHECKSUM_EN
      S_CK: if (hs) state_d = capture ? S_HEAD : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      seq_q     <= 8'd0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      prev0_q   <= 64'd0;
      prev1_q   <= 64'd0;
      delta0_q  <= 64'd0;
      delta1_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (capture) begin
        prev0_q  <= Count0;
        prev1_q  <= Count1;
        delta0_q <= Count0 - prev0_q;
        delta1_q <= Count1 - prev1_q;
      end
    end
  end

  assign Overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_count_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_count_reporter: table vectors, directed corner sequences and randomized frames vs. a frame-level model.
module tb_count_reporter;

`ifdef REPORTER_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [63:0] Count0 = '0;
  logic [63:0] Count1 = '0;
  logic        Sample = 1'b0;
  logic        Dready = 1'b0;
  logic [15:0] Dout;
  logic        Dvalid, Dlast, Busy, Overrun;

  count_reporter #(.HDR_TAG(8'hA5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Count0(Count0), .Count1(Count1),
    .Sample(Sample), .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready),
    .Dlast(Dlast), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] m_prev0, m_prev1;
  logic [7:0]  m_seq;

  typedef struct {
    logic [63:0] c0;
    logic [63:0] c1;
    logic [15:0] hdr;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [15:0] ck;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] fold(input logic [63:0] v);
    return v[63:48] ^ v[47:32] ^ v[31:16] ^ v[15:0];
  endfunction

  // Frame-level reference: deltas are plain 64-bit differences against the previous snapshot.
  task automatic model_frame(input logic [63:0] c0, input logic [63:0] c1,
                             output logic [15:0] hdr, output logic [63:0] d0,
                             output logic [63:0] d1, output logic [15:0] ck);
    d0  = c0 - m_prev0;
    d1  = c1 - m_prev1;
    hdr = {8'hA5, m_seq};
    ck  = hdr ^ fold(d0) ^ fold(d1);
    m_prev0 = c0;
    m_prev1 = c1;
    m_seq   = m_seq + 8'd1;
  endtask

  task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1, input string tag);
    chk($sformatf("%s_idle_valid", tag), Dvalid, 1'b0);
    Count0 = c0;
    Count1 = c1;
    Sample = 1'b1;
    tick();
    Sample = 1'b0;
    chk($sformatf("%s_latency", tag), Dvalid, 1'b1);
  endtask

  task automatic collect_frame(input logic [15:0] hdr, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [15:0] ck, input int ready_pct, input int stall_at,
                               input int pulses, input string tag);
    logic [15:0] exp [10];
    int k, g, stall;
    bit rdy;
    k = 0; g = 0; stall = 0;
    exp[0] = hdr;
    for (int i = 0; i < 4; i++) begin
      exp[1+i] = d0[63-16*i -: 16];
      exp[5+i] = d1[63-16*i -: 16];
    end
    exp[9] = ck;
    while (k < NB && g < 400) begin
      chk($sformatf("%s_valid", tag), Dvalid, 1'b1);
      chk($sformatf("%s_beat%0d", tag, k), Dout, exp[k]);
      chk($sformatf("%s_last%0d", tag, k), Dlast, (k == NB-1));
      if (k == stall_at && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = ($urandom_range(0, 99) < ready_pct);
      end
      Dready = rdy;
      Sample = (g == 1 && pulses >= 1) || (g == 3 && pulses >= 2) || (g == 5 && pulses >= 3);
      tick();
      if (rdy) k++;
      g++;
    end
    Dready = 1'b0;
    Sample = 1'b0;
    chk($sformatf("%s_handshakes", tag), k, NB);
  endtask

  initial begin
    logic [15:0] hdr, ck;
    logic [63:0] d0, d1, c0, c1;

    tbl[0] = '{64'h0000_0001_0000_0005, 64'h3,  16'hA500, 64'h0000_0001_0000_0005, 64'h3, 16'hA507};
    tbl[1] = '{64'h0000_0001_0000_0009, 64'h3,  16'hA501, 64'h4, 64'h0, 16'hA505};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h3,  16'hA502, 64'hFFFF_FFFE_FFFF_FFF5, 64'h0, 16'hA509};
    tbl[3] = '{64'h1,                   64'h10, 16'hA503, 64'h3, 64'hD, 16'hA50D};
    m_prev0 = '0; m_prev1 = '0; m_seq = '0;

    #23;
    chk("rst_dout", Dout, 16'h0);
    chk("rst_dvalid", Dvalid, 1'b0);
    chk("rst_dlast", Dlast, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_overrun", Overrun, 1'b0);
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      model_frame(tbl[i].c0, tbl[i].c1, hdr, d0, d1, ck);
      start_frame(tbl[i].c0, tbl[i].c1, $sformatf("tbl%0d", i));
      collect_frame(tbl[i].hdr, tbl[i].d0, tbl[i].d1, tbl[i].ck, 100, -1, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_end_busy", i), Busy, 1'b0);
    end

    // Backpressure: 5 stalled cycles on beat 2.
    c0 = 64'h1234_5678_9ABC_DEF0; c1 = 64'h10;
    model_frame(c0, c1, hdr, d0, d1, ck);
    start_frame(c0, c1, "bp");
    collect_frame(hdr, d0, d1, ck, 100, 2, 0, "bp");
    chk("bp_end_busy", Busy, 1'b0);

    // Queueing: one request during a frame runs back-to-back; two more in the next frame overrun.
    c0 = 64'h2000; c1 = 64'h3000;
    model_frame(c0, c1, hdr, d0, d1, ck);
    start_frame(c0, c1, "q1");
    Count0 = 64'h2100; Count1 = 64'h3005;
    collect_frame(hdr, d0, d1, ck, 100, -1, 1, "q1");
    chk("q1_overrun", Overrun, 1'b0);
    chk("q1_b2b_valid", Dvalid, 1'b1);
    model_frame(64'h2100, 64'h3005, hdr, d0, d1, ck);
    Count0 = 64'h2150; Count1 = 64'h2FFF;
    collect_frame(hdr, d0, d1, ck, 100, -1, 2, "q2");
    chk("q2_overrun", Overrun, 1'b1);
    chk("q2_b2b_valid", Dvalid, 1'b1);
    model_frame(64'h2150, 64'h2FFF, hdr, d0, d1, ck);
    Count0 = 64'hAAAA;
    collect_frame(hdr, d0, d1, ck, 100, -1, 0, "q3");
    chk("q3_end_busy", Busy, 1'b0);

    // Asynchronous reset in the middle of a frame.
    c0 = 64'h5555; c1 = 64'h6666;
    model_frame(c0, c1, hdr, d0, d1, ck);
    start_frame(c0, c1, "ar");
    Dready = 1'b1;
    tick();
    tick();
    Reset_n = 1'b0;
    #1;
    chk("ar_dvalid", Dvalid, 1'b0);
    chk("ar_busy", Busy, 1'b0);
    chk("ar_dout", Dout, 16'h0);
    chk("ar_dlast", Dlast, 1'b0);
    chk("ar_overrun", Overrun, 1'b0);
    Dready = 1'b0;
    #10;
    Reset_n = 1'b1;
    m_prev0 = '0; m_prev1 = '0; m_seq = '0;
    tick();
    c0 = 64'hDEAD_BEEF; c1 = 64'h7;
    model_frame(c0, c1, hdr, d0, d1, ck);
    chk("ar_model_hdr", hdr, 16'hA500);
    start_frame(c0, c1, "ar2");
    collect_frame(hdr, d0, d1, ck, 100, -1, 0, "ar2");

    // Randomized frames with random backpressure; counts change freely between captures.
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 2))
        0: begin c0 = {$urandom, $urandom}; c1 = {$urandom, $urandom}; end
        1: begin c0 = m_prev0 + 64'($urandom_range(0, 1000)); c1 = m_prev1 + 64'($urandom_range(0, 9)); end
        default: begin c0 = m_prev0 - 64'($urandom_range(1, 50)); c1 = {$urandom, $urandom}; end
      endcase
      model_frame(c0, c1, hdr, d0, d1, ck);
      start_frame(c0, c1, $sformatf("rnd%0d", f));
      Count0 = {$urandom, $urandom};
      Count1 = {$urandom, $urandom};
      collect_frame(hdr, d0, d1, ck, $urandom_range(30, 100), -1, 0, $sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_end_busy", f), Busy, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    chk("end_overrun", Overrun, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
